// File: rtl/apb_slave_mem_ws_if.sv
// APB4 completer bus bundle for apb_slave_mem_ws.
// The requester drives the request signals; the completer returns prdata/pready/pslverr.
interface apb_slave_mem_ws_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned NBYTES = DATA_WIDTH / 8;

  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [NBYTES-1:0]     pstrb;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_slave_mem_ws.sv
// Parametrised APB4 completer RAM with byte strobes, programmable wait states
// and PSLVERR on out-of-range or misaligned accesses.
module apb_slave_mem_ws #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MEM_DEPTH   = 64,
  parameter int unsigned WS_WIDTH    = 4,
  parameter int unsigned ALIGN_CHECK = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [WS_WIDTH-1:0] ws_cfg,
  apb_slave_mem_ws_if.slave   s_apb
);
  localparam int unsigned NBYTES = DATA_WIDTH / 8;
  localparam int unsigned LSB    = (NBYTES > 1) ? $clog2(NBYTES) : 0;
  localparam int unsigned IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [WS_WIDTH-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  pwrite_q, pwrite_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic [ADDR_WIDTH-1:0] word_addr;
  logic [IDX_W-1:0]      setup_idx;
  logic                  out_of_range;
  logic                  misaligned;
  logic                  setup_err;
  logic                  wr_commit;

  // Full-width range compare so addresses past the array never alias onto it.
  always_comb begin
    word_addr    = s_apb.paddr >> LSB;
    setup_idx    = word_addr[IDX_W-1:0];
    out_of_range = (word_addr >= ADDR_WIDTH'(MEM_DEPTH));
    misaligned   = (ALIGN_CHECK != 0) && ((s_apb.paddr & ADDR_WIDTH'(NBYTES - 1)) != '0);
    setup_err    = out_of_range | misaligned;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      pwrite_q <= 1'b0;
      err_q    <= 1'b0;
      prdata_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      pwrite_q <= pwrite_d;
      err_q    <= err_d;
      prdata_q <= prdata_d;
    end
  end

  // With zero wait states DONE is entered from the setup edge, so the RAM is
  // read at the live decoded index rather than the captured one.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    pwrite_d = pwrite_q;
    err_d    = err_q;
    prdata_d = prdata_q;
    unique case (state_q)
      IDLE: begin
        prdata_d = '0;
        if (s_apb.psel && !s_apb.penable) begin
          idx_d    = setup_idx;
          pwrite_d = s_apb.pwrite;
          err_d    = setup_err;
          cnt_d    = ws_cfg;
          if (ws_cfg == '0) begin
            state_d  = DONE;
            prdata_d = (setup_err || s_apb.pwrite) ? '0 : mem[setup_idx];
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (!s_apb.psel) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == WS_WIDTH'(1)) begin
          state_d  = DONE;
          cnt_d    = '0;
          prdata_d = (err_q || pwrite_q) ? '0 : mem[idx_q];
        end else begin
          cnt_d = cnt_q - WS_WIDTH'(1);
        end
      end
      DONE: begin
        state_d  = IDLE;
        prdata_d = '0;
      end
      default: begin
        state_d  = IDLE;
        cnt_d    = '0;
        prdata_d = '0;
      end
    endcase
  end

  always_comb begin
    s_apb.pready  = (state_q == DONE);
    s_apb.pslverr = (state_q == DONE) && err_q;
    s_apb.prdata  = prdata_q;
  end

  assign wr_commit = rst_n && (state_q == DONE) && s_apb.psel && s_apb.penable
                     && pwrite_q && !err_q;

  always_ff @(posedge clk) begin
    if (wr_commit) begin
      for (int unsigned i = 0; i < NBYTES; i++) begin
        if (s_apb.pstrb[i]) begin
          mem[idx_q][i*8 +: 8] <= s_apb.pwdata[i*8 +: 8];
        end
      end
    end
  end
endmodule

// File: tb/tb_apb_slave_mem_ws.sv
// Directed bench for apb_slave_mem_ws: two instances share stimulus, one with
// alignment checking enabled and one with it disabled.
module tb_apb_slave_mem_ws;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;
  logic [3:0]  ws_cfg;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc;
  logic [31:0] rd_a, rd_b;
  logic        err_a, err_b;

  always #5 clk = ~clk;

  apb_slave_mem_ws_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_a ();
  apb_slave_mem_ws_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_b ();

  assign bus_a.psel = psel;     assign bus_b.psel = psel;
  assign bus_a.penable = penable; assign bus_b.penable = penable;
  assign bus_a.pwrite = pwrite; assign bus_b.pwrite = pwrite;
  assign bus_a.paddr = paddr;   assign bus_b.paddr = paddr;
  assign bus_a.pwdata = pwdata; assign bus_b.pwdata = pwdata;
  assign bus_a.pstrb = pstrb;   assign bus_b.pstrb = pstrb;

  apb_slave_mem_ws #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(64),
                     .WS_WIDTH(4), .ALIGN_CHECK(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .ws_cfg(ws_cfg), .s_apb(bus_a.slave));

  apb_slave_mem_ws #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(64),
                     .WS_WIDTH(4), .ALIGN_CHECK(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .ws_cfg(ws_cfg), .s_apb(bus_b.slave));

  // Setup then access; returns in the cycle pready is seen (or budget runs out).
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [3:0] st, input logic [3:0] ws, input logic [3:0] ws_mid);
    @(posedge clk); #1;
    ws_cfg = ws; psel = 1'b1; penable = 1'b0; pwrite = wr;
    paddr = addr; pwdata = wd; pstrb = st;
    @(posedge clk); #1;
    penable = 1'b1; ws_cfg = ws_mid; cyc = 1;
    while (bus_a.pready !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    rd_a = bus_a.prdata; err_a = bus_a.pslverr;
    rd_b = bus_b.prdata; err_b = bus_b.pslverr;
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; ws_cfg = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({bus_a.pready, bus_a.pslverr, bus_a.prdata} !== 34'h0) begin
      n_err++;
      $display("FAIL reset_a got rdy=%b err=%b rd=%h exp 0/0/0", bus_a.pready, bus_a.pslverr, bus_a.prdata);
    end
    n_cmp++;
    if ({bus_b.pready, bus_b.pslverr, bus_b.prdata} !== 34'h0) begin
      n_err++;
      $display("FAIL reset_b got rdy=%b err=%b rd=%h exp 0/0/0", bus_b.pready, bus_b.pslverr, bus_b.prdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_zero_ws();
    xfer(1'b1, 32'h0F0, 32'h000A_3210, 4'hF, 4'd0, 4'd0);
    n_cmp++;
    if (cyc !== 1 || err_a !== 1'b0) begin
      n_err++;
      $display("FAIL ws0_write got cyc=%0d err=%b exp 1/0", cyc, err_a);
    end
    xfer(1'b0, 32'h0F0, 32'h0, 4'h0, 4'd0, 4'd0);
    n_cmp++;
    if (rd_a !== 32'h000A_3210 || cyc !== 1 || err_a !== 1'b0) begin
      n_err++;
      $display("FAIL ws0_read got rd=%h cyc=%0d err=%b exp 000a3210/1/0", rd_a, cyc, err_a);
    end
    go_idle();
    n_cmp++;
    if (bus_a.pready !== 1'b0 || bus_a.prdata !== 32'h0) begin
      n_err++;
      $display("FAIL ws0_after got rdy=%b rd=%h exp 0/00000000", bus_a.pready, bus_a.prdata);
    end
  endtask

  task automatic test_strobes();
    xfer(1'b1, 32'h010, 32'hFFFF_FFFF, 4'hF, 4'd0, 4'd0);
    xfer(1'b1, 32'h010, 32'h1234_5678, 4'b0010, 4'd0, 4'd0);
    xfer(1'b0, 32'h010, 32'h0, 4'h0, 4'd0, 4'd0);
    n_cmp++;
    if (rd_a !== 32'hFFFF_56FF) begin
      n_err++;
      $display("FAIL strb_lane1 got %h exp ffff56ff", rd_a);
    end
    xfer(1'b1, 32'h010, 32'h0000_0000, 4'b0000, 4'd0, 4'd0);
    xfer(1'b0, 32'h010, 32'h0, 4'h0, 4'd0, 4'd0);
    n_cmp++;
    if (rd_a !== 32'hFFFF_56FF) begin
      n_err++;
      $display("FAIL strb_none got %h exp ffff56ff", rd_a);
    end
    go_idle();
  endtask

  task automatic test_wait_states();
    xfer(1'b0, 32'h0F0, 32'h0, 4'h0, 4'd3, 4'd3);
    n_cmp++;
    if (cyc !== 4 || rd_a !== 32'h000A_3210) begin
      n_err++;
      $display("FAIL ws3_read got cyc=%0d rd=%h exp 4/000a3210", cyc, rd_a);
    end
    xfer(1'b0, 32'h0F0, 32'h0, 4'h0, 4'd3, 4'd0);
    n_cmp++;
    if (cyc !== 4 || rd_a !== 32'h000A_3210) begin
      n_err++;
      $display("FAIL ws3_cfg_change got cyc=%0d rd=%h exp 4/000a3210", cyc, rd_a);
    end
    go_idle();
  endtask

  task automatic test_range();
    xfer(1'b1, 32'h000, 32'hCAFE_F00D, 4'hF, 4'd0, 4'd0);
    xfer(1'b1, 32'h0FC, 32'h0BAD_CAFE, 4'hF, 4'd0, 4'd0);
    n_cmp++;
    if (err_a !== 1'b0) begin
      n_err++;
      $display("FAIL range_last_word got err=%b exp 0", err_a);
    end
    xfer(1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF, 4'd0, 4'd0);
    n_cmp++;
    if (err_a !== 1'b1 || cyc !== 1) begin
      n_err++;
      $display("FAIL range_write got err=%b cyc=%0d exp 1/1", err_a, cyc);
    end
    xfer(1'b0, 32'h000, 32'h0, 4'h0, 4'd0, 4'd0);
    n_cmp++;
    if (rd_a !== 32'hCAFE_F00D || err_a !== 1'b0) begin
      n_err++;
      $display("FAIL range_no_alias got rd=%h err=%b exp cafef00d/0", rd_a, err_a);
    end
    xfer(1'b0, 32'h0FC, 32'h0, 4'h0, 4'd0, 4'd0);
    n_cmp++;
    if (rd_a !== 32'h0BAD_CAFE || err_a !== 1'b0) begin
      n_err++;
      $display("FAIL range_read_last got rd=%h err=%b exp 0badcafe/0", rd_a, err_a);
    end
    xfer(1'b0, 32'h100, 32'h0, 4'h0, 4'd0, 4'd0);
    n_cmp++;
    if (rd_a !== 32'h0 || err_a !== 1'b1) begin
      n_err++;
      $display("FAIL range_read got rd=%h err=%b exp 00000000/1", rd_a, err_a);
    end
    go_idle();
  endtask

  task automatic test_align();
    xfer(1'b0, 32'h0F1, 32'h0, 4'h0, 4'd0, 4'd0);
    n_cmp++;
    if (err_a !== 1'b1 || rd_a !== 32'h0) begin
      n_err++;
      $display("FAIL align_on got err=%b rd=%h exp 1/00000000", err_a, rd_a);
    end
    n_cmp++;
    if (err_b !== 1'b0 || rd_b !== 32'h000A_3210) begin
      n_err++;
      $display("FAIL align_off got err=%b rd=%h exp 0/000a3210", err_b, rd_b);
    end
    go_idle();
  endtask

  task automatic test_abort();
    xfer(1'b1, 32'h030, 32'hAAAA_0000, 4'hF, 4'd0, 4'd0);
    xfer(1'b1, 32'h030, 32'h5555_5555, 4'hF, 4'd0, 4'd0);
    psel = 1'b0; penable = 1'b0;
    xfer(1'b0, 32'h030, 32'h0, 4'h0, 4'd0, 4'd0);
    n_cmp++;
    if (rd_a !== 32'hAAAA_0000) begin
      n_err++;
      $display("FAIL abort_done_write got %h exp aaaa0000", rd_a);
    end
    go_idle();
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h030; ws_cfg = 4'd3;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_cmp++;
    if (bus_a.pready !== 1'b0 || bus_a.prdata !== 32'h0) begin
      n_err++;
      $display("FAIL abort_access got rdy=%b rd=%h exp 0/00000000", bus_a.pready, bus_a.prdata);
    end
    psel = 1'b1; penable = 1'b1; ws_cfg = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (bus_a.pready !== 1'b0) begin
      n_err++;
      $display("FAIL penable_in_idle got rdy=%b exp 0", bus_a.pready);
    end
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    ws_cfg = 4'd3; psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 32'h020; pwdata = 32'h5555_5555; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus_a.pready, bus_a.pslverr, bus_a.prdata} !== 34'h0) begin
      n_err++;
      $display("FAIL rst_access got rdy=%b err=%b rd=%h exp 0/0/0", bus_a.pready, bus_a.pslverr, bus_a.prdata);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; psel = 1'b0; penable = 1'b0;
    xfer(1'b1, 32'h020, 32'h1111_1111, 4'hF, 4'd0, 4'd0);
    n_cmp++;
    if (cyc !== 1 || err_a !== 1'b0) begin
      n_err++;
      $display("FAIL rst_after_write got cyc=%0d err=%b exp 1/0", cyc, err_a);
    end
    xfer(1'b0, 32'h020, 32'h0, 4'h0, 4'd0, 4'd0);
    n_cmp++;
    if (rd_a !== 32'h1111_1111 || err_a !== 1'b0) begin
      n_err++;
      $display("FAIL rst_after_read got rd=%h err=%b exp 11111111/0", rd_a, err_a);
    end
    go_idle();
    xfer(1'b0, 32'h0F0, 32'h0, 4'h0, 4'd0, 4'd0);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (rd_a !== 32'h000A_3210 || bus_a.pready !== 1'b0 || bus_a.prdata !== 32'h0) begin
      n_err++;
      $display("FAIL rst_done got pre_rd=%h rdy=%b rd=%h exp 000a3210/0/00000000", rd_a, bus_a.pready, bus_a.prdata);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; psel = 1'b0; penable = 1'b0;
    xfer(1'b0, 32'h020, 32'h0, 4'h0, 4'd0, 4'd0);
    n_cmp++;
    if (rd_a !== 32'h1111_1111 || cyc !== 1) begin
      n_err++;
      $display("FAIL rst_done_recover got rd=%h cyc=%0d exp 11111111/1", rd_a, cyc);
    end
    go_idle();
  endtask

  initial begin
    test_reset();
    test_zero_ws();
    test_strobes();
    test_wait_states();
    test_range();
    test_align();
    test_abort();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
